// File: rtl/wb_pkg.sv
// ============================================================================
// Module      : wb_pkg
// Description : Shared constants and types for the register-file write-back
//               port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_pkg;

    localparam int NUM_REQ    = 3;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_CSR = 2;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

    // Index width that stays legal for a single requester.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin grant: search starts at the pointer
//               and wraps modulo N; returns a one-hot grant and its index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import wb_pkg::*;
#(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_valid_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_any_o
);

    int               w_pos;
    logic [IDX_W-1:0] w_idx;

    // Walking offsets from the pointer is the rotate; the first hit is the
    // priority encode; storing the absolute position is the unrotate.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        grant_any_o = 1'b0;
        w_pos       = 0;
        w_idx       = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = int'(rr_ptr_i) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            w_idx = IDX_W'(w_pos);
            if (!grant_any_o && req_valid_i[w_idx]) begin
                grant_any_o    = 1'b1;
                grant_o[w_idx] = 1'b1;
                grant_idx_o    = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the register-file write port between write-back
//               requesters with round-robin grants and a registered port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_port_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int reg_addr_width = 5,
    parameter int reg_data_width = 32
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_REQ-1:0]                       req_valid,
    input  logic [NUM_REQ*reg_addr_width-1:0]        req_addr,
    input  logic [NUM_REQ*reg_data_width-1:0]        req_data,
    output logic [NUM_REQ-1:0]                       req_ready,
    input  logic                                     wb_stall,
    output logic [reg_addr_width-1:0]                wr_addr,
    output logic [reg_data_width-1:0]                wr_data,
    output logic                                     write_back_en,
    output logic [wb_pkg::ptr_width(NUM_REQ)-1:0]    rr_ptr
);

    import wb_pkg::*;

    localparam int PTR_W = ptr_width(NUM_REQ);

    logic [NUM_REQ-1:0]        w_valid_gated;
    logic [NUM_REQ-1:0]        w_grant;
    logic [PTR_W-1:0]          w_gnt_idx;
    logic                      w_any;
    logic [reg_addr_width-1:0] w_sel_addr;
    logic [reg_data_width-1:0] w_sel_data;

    logic [PTR_W-1:0]          rr_ptr_q,  rr_ptr_d;
    logic [reg_addr_width-1:0] wr_addr_q, wr_addr_d;
    logic [reg_data_width-1:0] wr_data_q, wr_data_d;
    logic                      wb_en_q,   wb_en_d;

    // Gating valid (rather than the grant) keeps the arbiter's any-flag honest
    // so stall and reset also freeze the pointer and the output register.
    assign w_valid_gated = (rst || wb_stall) ? '0 : req_valid;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (PTR_W)
    ) u_rr_arbiter (
        .req_valid_i (w_valid_gated),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (w_grant),
        .grant_idx_o (w_gnt_idx),
        .grant_any_o (w_any)
    );

    assign req_ready  = w_grant;
    assign w_sel_addr = req_addr[w_gnt_idx*reg_addr_width +: reg_addr_width];
    assign w_sel_data = req_data[w_gnt_idx*reg_data_width +: reg_data_width];

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wb_en_d   = 1'b0;
        if (w_any) begin
            rr_ptr_d  = (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
            wr_addr_d = w_sel_addr;
            wr_data_d = w_sel_data;
            // x0 is hard-wired zero: complete the handshake, skip the strobe.
            wb_en_d   = |w_sel_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wb_en_q   <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wb_en_q   <= wb_en_d;
        end
    end

    assign rr_ptr        = rr_ptr_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign write_back_en = wb_en_q;

endmodule

`default_nettype wire
